// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per clock, start/busy/done handshake.
// Optional signed division is enabled by defining DIV_SIGNED_EN.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_r, quo_r, dvs_r;
  logic             dz_r;
  logic             accept, dvs_zero;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   shifted, trial;
  logic             ge;
  logic [WIDTH-1:0] rem_next, quo_next;
  logic [WIDTH-1:0] quo_final, rem_final;

`ifdef DIV_SIGNED_EN
  logic sdvd, sdvs;
  logic neg_q_r, neg_r_r;

  // Magnitudes at start; signs reapplied in FIN so latency is unchanged.
  assign sdvd      = is_signed & dividend[WIDTH-1];
  assign sdvs      = is_signed & divisor[WIDTH-1];
  assign dvd_mag   = sdvd ? WIDTH'(-dividend) : dividend;
  assign dvs_mag   = sdvs ? WIDTH'(-divisor) : divisor;
  assign quo_final = neg_q_r ? WIDTH'(-quo_r) : quo_r;
  assign rem_final = neg_r_r ? WIDTH'(-rem_r) : rem_r;
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign dvd_mag          = dividend;
  assign dvs_mag          = divisor;
  assign quo_final        = quo_r;
  assign rem_final        = rem_r;
`endif

  assign dvs_zero = (divisor == '0);

  // Trial subtraction; a set top bit of the shifted remainder always exceeds the divisor.
  assign shifted  = {rem_r, quo_r[WIDTH-1]};
  assign trial    = shifted - {1'b0, dvs_r};
  assign ge       = shifted[WIDTH] | ~trial[WIDTH];
  assign rem_next = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_next = {quo_r[WIDTH-2:0], ge};

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          accept  = 1'b1;
          state_d = dvs_zero ? FIN : CALC;
        end
      end
      CALC: begin
        if (flush)                  state_d = IDLE;
        else if (cnt == CW'(1))     state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      dvs_r     <= '0;
      dz_r      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_SIGNED_EN
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            busy  <= 1'b1;
            rem_r <= '0;
            dvs_r <= dvs_mag;
            dz_r  <= dvs_zero;
            quo_r <= dvs_zero ? dividend : dvd_mag;
            cnt   <= dvs_zero ? '0 : CW'(WIDTH);
`ifdef DIV_SIGNED_EN
            neg_q_r <= ~dvs_zero & (sdvd ^ sdvs);
            neg_r_r <= ~dvs_zero & sdvd;
`endif
          end
        end
        CALC: begin
          if (flush) begin
            busy <= 1'b0;
            cnt  <= '0;
          end else begin
            rem_r <= rem_next;
            quo_r <= quo_next;
            cnt   <= cnt - CW'(1);
          end
        end
        FIN: begin
          busy <= 1'b0;
          if (!flush) begin
            done      <= 1'b1;
            div_zero  <= dz_r;
            quotient  <= dz_r ? '1 : quo_final;
            remainder <= dz_r ? quo_r : rem_final;
          end
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=32); expectations follow DIV_SIGNED_EN.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n, start, flush, is_signed;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_zero;
  logic [31:0] quotient, remainder;

  int errors = 0;
  int checks = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .div_zero(div_zero), .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one edge (the accept edge N).
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    dividend  = a;
    divisor   = b;
    is_signed = sgn;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Edges after the accept edge until done is seen, and cycles busy was high.
  task automatic wait_done(input int budget, output int edges, output int busy_cyc);
    edges = 0;
    busy_cyc = 0;
    while (!done && edges < budget) begin
      if (busy) busy_cyc++;
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; is_signed = 1'b0;
    dividend = '0; divisor = '0;
    tick(); tick();
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got=%b exp=0", div_zero); end
    checks++; if (quotient !== 32'h0) begin errors++; $display("FAIL reset_q got=%h exp=0", quotient); end
    checks++; if (remainder !== 32'h0) begin errors++; $display("FAIL reset_r got=%h exp=0", remainder); end
  endtask

  task automatic test_unsigned();
    int e, b;
    launch(32'd100, 32'd7, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL uns_busy_after_start got=%b exp=1", busy); end
    wait_done(60, e, b);
    checks++; if (e !== 33) begin errors++; $display("FAIL uns_latency got=%0d exp=33", e); end
    checks++; if (b !== 33) begin errors++; $display("FAIL uns_busy_cycles got=%0d exp=33", b); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL uns_busy_at_done got=%b exp=0", busy); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL uns_q got=%0d exp=14", quotient); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL uns_r got=%0d exp=2", remainder); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL uns_dz got=%b exp=0", div_zero); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL uns_done_pulse got=%b exp=0", done); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL uns_q_held got=%0d exp=14", quotient); end
  endtask

  task automatic test_div_zero();
    int e, b;
    launch(32'hDEADBEEF, 32'h0, 1'b0);
    wait_done(60, e, b);
    checks++; if (e !== 1) begin errors++; $display("FAIL dz_latency got=%0d exp=1", e); end
    checks++; if (quotient !== 32'hFFFFFFFF) begin errors++; $display("FAIL dz_q got=%h exp=ffffffff", quotient); end
    checks++; if (remainder !== 32'hDEADBEEF) begin errors++; $display("FAIL dz_r got=%h exp=deadbeef", remainder); end
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got=%b exp=1", div_zero); end
    tick();
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag_held got=%b exp=1", div_zero); end
  endtask

  task automatic test_back_to_back();
    int e, b;
    launch(32'hFFFFFFFF, 32'h10, 1'b0);
    e = 0;
    while (!done && e < 60) begin
      if (e == 9) begin
        dividend = 32'd1; divisor = 32'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      e++;
    end
    start = 1'b0;
    checks++; if (e !== 33) begin errors++; $display("FAIL ign_latency got=%0d exp=33", e); end
    checks++; if (quotient !== 32'h0FFFFFFF) begin errors++; $display("FAIL ign_q got=%h exp=0fffffff", quotient); end
    checks++; if (remainder !== 32'hF) begin errors++; $display("FAIL ign_r got=%h exp=f", remainder); end
    launch(32'd50, 32'd5, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got=%b exp=1", busy); end
    checks++; if (quotient !== 32'h0FFFFFFF) begin errors++; $display("FAIL b2b_q_held got=%h exp=0fffffff", quotient); end
    wait_done(60, e, b);
    checks++; if (e !== 33) begin errors++; $display("FAIL b2b_latency got=%0d exp=33", e); end
    checks++; if (quotient !== 32'd10) begin errors++; $display("FAIL b2b_q got=%0d exp=10", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL b2b_r got=%0d exp=0", remainder); end
  endtask

  task automatic test_flush();
    int seen;
    launch(32'd1000, 32'd3, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b exp=0", busy); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_done got=%0d exp=0", seen); end
    checks++; if (quotient !== 32'd10) begin errors++; $display("FAIL flush_q_held got=%0d exp=10", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL flush_r_held got=%0d exp=0", remainder); end
    dividend = 32'd9; divisor = 32'd3; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_prio_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    int e, b;
    launch(32'd1000, 32'd3, 1'b0);
    for (int i = 0; i < 19; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%b exp=0", done); end
    checks++; if (quotient !== 32'h0) begin errors++; $display("FAIL rstmid_q got=%h exp=0", quotient); end
    checks++; if (remainder !== 32'h0) begin errors++; $display("FAIL rstmid_r got=%h exp=0", remainder); end
    launch(32'd1000, 32'd3, 1'b0);
    wait_done(60, e, b);
    checks++; if (e !== 33) begin errors++; $display("FAIL rstmid_latency got=%0d exp=33", e); end
    checks++; if (quotient !== 32'd333) begin errors++; $display("FAIL rstmid_q2 got=%0d exp=333", quotient); end
    checks++; if (remainder !== 32'd1) begin errors++; $display("FAIL rstmid_r2 got=%0d exp=1", remainder); end
  endtask

  task automatic test_signed();
    int e, b;
    logic [31:0] eq1, er1, eq2, er2, eq3, er3;
`ifdef DIV_SIGNED_EN
    eq1 = 32'hFFFFFFFD; er1 = 32'hFFFFFFFF;
    eq2 = 32'h80000000; er2 = 32'h0;
    eq3 = 32'hFFFFFFFD; er3 = 32'd1;
`else
    eq1 = 32'h7FFFFFFC; er1 = 32'd1;
    eq2 = 32'h0;        er2 = 32'h80000000;
    eq3 = 32'h0;        er3 = 32'd7;
`endif
    launch(32'hFFFFFFF9, 32'd2, 1'b1);
    wait_done(60, e, b);
    checks++; if (quotient !== eq1) begin errors++; $display("FAIL sgn_m7d2_q got=%h exp=%h", quotient, eq1); end
    checks++; if (remainder !== er1) begin errors++; $display("FAIL sgn_m7d2_r got=%h exp=%h", remainder, er1); end
    launch(32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_done(60, e, b);
    checks++; if (e !== 33) begin errors++; $display("FAIL sgn_ovf_latency got=%0d exp=33", e); end
    checks++; if (quotient !== eq2) begin errors++; $display("FAIL sgn_ovf_q got=%h exp=%h", quotient, eq2); end
    checks++; if (remainder !== er2) begin errors++; $display("FAIL sgn_ovf_r got=%h exp=%h", remainder, er2); end
    launch(32'd7, 32'hFFFFFFFE, 1'b1);
    wait_done(60, e, b);
    checks++; if (quotient !== eq3) begin errors++; $display("FAIL sgn_7dm2_q got=%h exp=%h", quotient, eq3); end
    checks++; if (remainder !== er3) begin errors++; $display("FAIL sgn_7dm2_r got=%h exp=%h", remainder, er3); end
    launch(32'hFFFFFFFB, 32'h0, 1'b1);
    wait_done(60, e, b);
    checks++; if (quotient !== 32'hFFFFFFFF) begin errors++; $display("FAIL sgn_dz_q got=%h exp=ffffffff", quotient); end
    checks++; if (remainder !== 32'hFFFFFFFB) begin errors++; $display("FAIL sgn_dz_r got=%h exp=fffffffb", remainder); end
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL sgn_dz_flag got=%b exp=1", div_zero); end
    is_signed = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_div_zero();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_signed();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
